// File: rtl/game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : game_sequencer
// Description : Step sequencer for the 8-square colour matching game. Shows
//               every square for a preview period, then takes two square
//               selections on confirm, reveals both for a fixed period and
//               compares their colour-pair ids. Tracks matched squares, the
//               number of pairs found and the miss count until all 4 pairs
//               are found.
// Revision    : 1.0 - initial release
// ============================================================================
module game_sequencer #(
  parameter int PREVIEW_CYCLES = 25_000_000,
  parameter int SHOW_CYCLES    = 25_000_000
) (
  input  logic        clk25MHz,
  input  logic        rst_n,
  input  logic        start,
  input  logic        confirm,
  input  logic [2:0]  cursor1,
  input  logic [2:0]  cursor2,
  input  logic [15:0] colors,
  output logic [3:0]  step,
  output logic [2:0]  secim1,
  output logic [2:0]  secim2,
  output logic [7:0]  matched,
  output logic [2:0]  score,
  output logic [7:0]  tries,
  output logic        match_pulse,
  output logic        miss_pulse
);

  // The timer is shared by the preview and the reveal phases, so it is sized
  // for the longer of the two with one bit of headroom.
  localparam int MAX_CYCLES = (PREVIEW_CYCLES > SHOW_CYCLES) ? PREVIEW_CYCLES : SHOW_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES) + 1;

  localparam logic [TIMER_W-1:0] PREVIEW_LAST = TIMER_W'(PREVIEW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SHOW_LAST    = TIMER_W'(SHOW_CYCLES - 1);

  localparam logic [2:0] SCORE_FULL  = 3'd4;
  localparam logic [7:0] TRIES_LIMIT = 8'hFF;

  // Step codes are consumed directly by the cursor and display blocks.
  typedef enum logic [3:0] {
    IDLE    = 4'b0000,
    PREVIEW = 4'b0001,
    SEL1    = 4'b0010,
    SEL2    = 4'b0011,
    SHOW    = 4'b0100,
    WIN     = 4'b0101
  } state_t;

  state_t state;
  state_t state_nx;

  logic               start_q;
  logic               confirm_q;
  logic [TIMER_W-1:0] timer;

  logic [TIMER_W-1:0] timer_nx;
  logic [2:0]         secim1_nx;
  logic [2:0]         secim2_nx;
  logic [7:0]         matched_nx;
  logic [2:0]         score_nx;
  logic [7:0]         tries_nx;
  logic               match_nx;
  logic               miss_nx;

  logic               start_rise;
  logic               confirm_rise;
  logic [1:0]         id1;
  logic [1:0]         id2;
  logic [2:0]         score_inc;
  logic [7:0]         pair_mask;

  // Button edges; history resets high so a button held through reset
  // must be released and pressed again before it counts.
  assign start_rise   = start & ~start_q;
  assign confirm_rise = confirm & ~confirm_q;

  // Colour-pair ids of the two latched squares, read live from the board.
  assign id1 = colors[{secim1, 1'b0} +: 2];
  assign id2 = colors[{secim2, 1'b0} +: 2];

  assign score_inc = score + 3'd1;
  assign pair_mask = (8'b1 << secim1) | (8'b1 << secim2);

  assign step = state;

  // Register the button history used for rising-edge detection.
  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      start_q   <= 1'b1;
      confirm_q <= 1'b1;
    end else begin
      start_q   <= start;
      confirm_q <= confirm;
    end
  end

  // State register.
  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Game datapath registers: timer, selections, board progress and pulses.
  always_ff @(posedge clk25MHz) begin
    if (!rst_n) begin
      timer       <= '0;
      secim1      <= 3'd0;
      secim2      <= 3'd0;
      matched     <= 8'h00;
      score       <= 3'd0;
      tries       <= 8'h00;
      match_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      timer       <= timer_nx;
      secim1      <= secim1_nx;
      secim2      <= secim2_nx;
      matched     <= matched_nx;
      score       <= score_nx;
      tries       <= tries_nx;
      match_pulse <= match_nx;
      miss_pulse  <= miss_nx;
    end
  end

  // Next-state and next-datapath logic; everything holds unless a state acts.
  always_comb begin
    state_nx   = state;
    timer_nx   = timer;
    secim1_nx  = secim1;
    secim2_nx  = secim2;
    matched_nx = matched;
    score_nx   = score;
    tries_nx   = tries;
    match_nx   = 1'b0;
    miss_nx    = 1'b0;

    case (state)
      // A new game clears the board from both the idle and win screens.
      IDLE, WIN: begin
        if (start_rise) begin
          state_nx   = PREVIEW;
          matched_nx = 8'h00;
          score_nx   = 3'd0;
          tries_nx   = 8'h00;
          timer_nx   = '0;
        end
      end

      PREVIEW: begin
        if (timer == PREVIEW_LAST) begin
          state_nx = SEL1;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      // Already matched squares cannot be picked again.
      SEL1: begin
        if (confirm_rise && !matched[cursor1]) begin
          secim1_nx = cursor1;
          state_nx  = SEL2;
        end
      end

      // The second pick must differ from the first and be unmatched.
      SEL2: begin
        if (confirm_rise && (cursor2 != secim1) && !matched[cursor2]) begin
          secim2_nx = cursor2;
          timer_nx  = '0;
          state_nx  = SHOW;
        end
      end

      // Both squares stay revealed; the verdict is taken on the last cycle.
      SHOW: begin
        if (timer == SHOW_LAST) begin
          timer_nx = '0;
          if (id1 == id2) begin
            matched_nx = matched | pair_mask;
            score_nx   = score_inc;
            match_nx   = 1'b1;
            state_nx   = (score_inc == SCORE_FULL) ? WIN : SEL1;
          end else begin
            tries_nx = (tries == TRIES_LIMIT) ? tries : tries + 8'd1;
            miss_nx  = 1'b1;
            state_nx = SEL1;
          end
        end else begin
          timer_nx = timer + 1'b1;
        end
      end

      // Any unused code recovers to the idle screen.
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_sequencer
// Description : Directed self-checking bench for game_sequencer with short
//               preview/reveal periods and a fixed colour board where
//               square i and square i+4 share a colour-pair id.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_sequencer;

  localparam int PREVIEW_CYCLES = 4;
  localparam int SHOW_CYCLES    = 3;

  logic        clk25MHz;
  logic        rst_n;
  logic        start;
  logic        confirm;
  logic [2:0]  cursor1;
  logic [2:0]  cursor2;
  logic [15:0] colors;
  logic [3:0]  step;
  logic [2:0]  secim1;
  logic [2:0]  secim2;
  logic [7:0]  matched;
  logic [2:0]  score;
  logic [7:0]  tries;
  logic        match_pulse;
  logic        miss_pulse;

  int tests;
  int fails;

  game_sequencer #(
    .PREVIEW_CYCLES(PREVIEW_CYCLES),
    .SHOW_CYCLES   (SHOW_CYCLES)
  ) dut (
    .clk25MHz   (clk25MHz),
    .rst_n      (rst_n),
    .start      (start),
    .confirm    (confirm),
    .cursor1    (cursor1),
    .cursor2    (cursor2),
    .colors     (colors),
    .step       (step),
    .secim1     (secim1),
    .secim2     (secim2),
    .matched    (matched),
    .score      (score),
    .tries      (tries),
    .match_pulse(match_pulse),
    .miss_pulse (miss_pulse)
  );

  // 40 ns period clock.
  initial clk25MHz = 1'b0;
  always #20 clk25MHz = ~clk25MHz;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk25MHz);
    #1;
  endtask

  // One confirm press: high for one edge, then low for one edge.
  task automatic press_confirm();
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tick();
  endtask

  // Select c1 then c2 and run the reveal to the verdict cycle, where the
  // pulse and updated counters are visible.
  task automatic play_pair(input logic [2:0] c1, input logic [2:0] c2);
    cursor1 = c1;
    press_confirm();
    cursor2 = c2;
    press_confirm();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    tick();
    tests++; if (step !== 4'b0000) begin fails++; $display("FAIL reset_step got %b want 0000", step); end
    tests++; if ({secim1, secim2} !== 6'd0) begin fails++; $display("FAIL reset_secim got %0d/%0d want 0/0", secim1, secim2); end
    tests++; if (matched !== 8'h00 || score !== 3'd0 || tries !== 8'h00) begin fails++; $display("FAIL reset_counts got m=%h s=%0d t=%0d want 0/0/0", matched, score, tries); end
    tests++; if ({match_pulse, miss_pulse} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b want 00", {match_pulse, miss_pulse}); end
    rst_n = 1'b1;
    tick();
    tick();
    tests++; if (step !== 4'b0000) begin fails++; $display("FAIL held_start got %b want 0000", step); end
    start = 1'b0;
    tick();
    tests++; if (step !== 4'b0000) begin fails++; $display("FAIL idle_wait got %b want 0000", step); end
  endtask

  task automatic test_preview();
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (step !== 4'b0001) begin fails++; $display("FAIL preview_enter got %b want 0001", step); end
    for (int i = 0; i < PREVIEW_CYCLES - 1; i++) begin
      tick();
      tests++; if (step !== 4'b0001) begin fails++; $display("FAIL preview_hold%0d got %b want 0001", i, step); end
    end
    tick();
    tests++; if (step !== 4'b0010) begin fails++; $display("FAIL preview_exit got %b want 0010", step); end
  endtask

  task automatic test_match();
    cursor1 = 3'd2;
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tests++; if (step !== 4'b0011 || secim1 !== 3'd2) begin fails++; $display("FAIL sel1_latch got step=%b s1=%0d want 0011/2", step, secim1); end
    tick();
    cursor2 = 3'd2;
    press_confirm();
    tests++; if (step !== 4'b0011) begin fails++; $display("FAIL sel2_same_square got %b want 0011", step); end
    cursor2 = 3'd6;
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tests++; if (step !== 4'b0100 || secim2 !== 3'd6) begin fails++; $display("FAIL sel2_latch got step=%b s2=%0d want 0100/6", step, secim2); end
    tick();
    tests++; if (step !== 4'b0100) begin fails++; $display("FAIL show_hold1 got %b want 0100", step); end
    tick();
    tests++; if (step !== 4'b0100 || match_pulse !== 1'b0) begin fails++; $display("FAIL show_hold2 got %b/%b want 0100/0", step, match_pulse); end
    tick();
    tests++; if (step !== 4'b0010) begin fails++; $display("FAIL match_return got %b want 0010", step); end
    tests++; if (match_pulse !== 1'b1 || miss_pulse !== 1'b0) begin fails++; $display("FAIL match_pulse got %b%b want 10", match_pulse, miss_pulse); end
    tests++; if (matched !== 8'h44 || score !== 3'd1) begin fails++; $display("FAIL match_board got m=%h s=%0d want 44/1", matched, score); end
    tick();
    tests++; if (match_pulse !== 1'b0) begin fails++; $display("FAIL match_pulse_width got %b want 0", match_pulse); end
  endtask

  task automatic test_miss();
    play_pair(3'd0, 3'd1);
    tests++; if (miss_pulse !== 1'b1 || match_pulse !== 1'b0) begin fails++; $display("FAIL miss_pulse got %b%b want 01", miss_pulse, match_pulse); end
    tests++; if (tries !== 8'd1 || matched !== 8'h44 || score !== 3'd1) begin fails++; $display("FAIL miss_counts got t=%0d m=%h s=%0d want 1/44/1", tries, matched, score); end
    tests++; if (step !== 4'b0010) begin fails++; $display("FAIL miss_return got %b want 0010", step); end
    tick();
    tests++; if (miss_pulse !== 1'b0) begin fails++; $display("FAIL miss_pulse_width got %b want 0", miss_pulse); end
  endtask

  task automatic test_ignored();
    play_pair(3'd0, 3'd4);
    tests++; if (matched !== 8'h55 || score !== 3'd2) begin fails++; $display("FAIL pair04 got m=%h s=%0d want 55/2", matched, score); end
    play_pair(3'd1, 3'd5);
    tests++; if (matched !== 8'h77 || score !== 3'd3 || step !== 4'b0010) begin fails++; $display("FAIL pair15 got m=%h s=%0d st=%b want 77/3/0010", matched, score, step); end
    cursor1 = 3'd0;
    press_confirm();
    tests++; if (step !== 4'b0010 || secim1 !== 3'd1) begin fails++; $display("FAIL sel1_matched got st=%b s1=%0d want 0010/1", step, secim1); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tests++; if (step !== 4'b0010 || matched !== 8'h77) begin fails++; $display("FAIL start_in_sel1 got st=%b m=%h want 0010/77", step, matched); end
    cursor1 = 3'd3;
    start   = 1'b1;
    confirm = 1'b1;
    tick();
    start   = 1'b0;
    confirm = 1'b0;
    tests++; if (step !== 4'b0011 || secim1 !== 3'd3) begin fails++; $display("FAIL start_confirm_sel1 got st=%b s1=%0d want 0011/3", step, secim1); end
    tick();
    cursor2 = 3'd5;
    press_confirm();
    tests++; if (step !== 4'b0011) begin fails++; $display("FAIL sel2_matched got %b want 0011", step); end
  endtask

  task automatic test_win();
    cursor2 = 3'd7;
    press_confirm();
    tick();
    tick();
    tests++; if (step !== 4'b0101 || score !== 3'd4 || matched !== 8'hFF) begin fails++; $display("FAIL win got st=%b s=%0d m=%h want 0101/4/ff", step, score, matched); end
    tests++; if (match_pulse !== 1'b1) begin fails++; $display("FAIL win_pulse got %b want 1", match_pulse); end
    press_confirm();
    tests++; if (step !== 4'b0101) begin fails++; $display("FAIL confirm_in_win got %b want 0101", step); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (step !== 4'b0001) begin fails++; $display("FAIL win_restart got %b want 0001", step); end
    tests++; if (matched !== 8'h00 || score !== 3'd0 || tries !== 8'd0) begin fails++; $display("FAIL restart_clear got m=%h s=%0d t=%0d want 0/0/0", matched, score, tries); end
    tests++; if (secim1 !== 3'd3 || secim2 !== 3'd7) begin fails++; $display("FAIL secim_hold got %0d/%0d want 3/7", secim1, secim2); end
    for (int i = 0; i < PREVIEW_CYCLES; i++) tick();
    tests++; if (step !== 4'b0010) begin fails++; $display("FAIL restart_sel1 got %b want 0010", step); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 255; i++) play_pair(3'd0, 3'd1);
    tests++; if (tries !== 8'd255) begin fails++; $display("FAIL tries_255 got %0d want 255", tries); end
    play_pair(3'd2, 3'd3);
    tests++; if (tries !== 8'd255 || miss_pulse !== 1'b1) begin fails++; $display("FAIL tries_sat got t=%0d p=%b want 255/1", tries, miss_pulse); end
  endtask

  task automatic test_reset_mid();
    play_pair(3'd2, 3'd6);
    cursor1 = 3'd0;
    press_confirm();
    cursor2 = 3'd4;
    confirm = 1'b1;
    tick();
    confirm = 1'b0;
    tests++; if (step !== 4'b0100 || matched !== 8'h44) begin fails++; $display("FAIL pre_reset_show got st=%b m=%h want 0100/44", step, matched); end
    rst_n = 1'b0;
    tick();
    tests++; if (step !== 4'b0000 || matched !== 8'h00 || score !== 3'd0 || tries !== 8'd0) begin fails++; $display("FAIL mid_reset got st=%b m=%h s=%0d t=%0d want all 0", step, matched, score, tries); end
    tests++; if ({secim1, secim2} !== 6'd0 || {match_pulse, miss_pulse} !== 2'b00) begin fails++; $display("FAIL mid_reset_sel got %0d/%0d p=%b%b want 0/0/00", secim1, secim2, match_pulse, miss_pulse); end
    rst_n = 1'b1;
    tick();
    tick();
    tests++; if (step !== 4'b0000) begin fails++; $display("FAIL post_reset_idle got %b want 0000", step); end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    confirm = 1'b0;
    cursor1 = 3'd0;
    cursor2 = 3'd0;
    colors  = 16'b11_10_01_00_11_10_01_00;
    test_reset();
    test_preview();
    test_match();
    test_miss();
    test_ignored();
    test_win();
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
